// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Multiplies by shift-add and divides by restoring shift-subtract, one step per cycle.
// Both work on operand magnitudes; the signs are fixed up when the results are written.
module mult_div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rsData,
    input  logic [31:0] rtData,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q;
    logic [5:0]  count_q;
    logic        is_div_q;
    logic        neg_q;       // quotient/product must be negated
    logic        neg_rem_q;   // dividend was negative, so the remainder takes its sign
    logic [31:0] b_q;         // multiplicand or divisor magnitude
    logic [31:0] work_hi_q;   // partial product upper half, or partial remainder
    logic [31:0] work_lo_q;   // multiplier bits, or dividend bits turning into quotient
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;

    // Operand decode at latch time
    logic        is_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_by_zero;

    always_comb begin
        is_signed   = ~op[0];
        a_neg       = is_signed & rsData[31];
        b_neg       = is_signed & rtData[31];
        a_mag       = a_neg ? (~rsData + 32'd1) : rsData;
        b_mag       = b_neg ? (~rtData + 32'd1) : rtData;
        div_by_zero = op[1] & (rtData == 32'd0);
    end

    // One iteration step and the sign-corrected final result
    logic [32:0] add_sum;
    logic [32:0] mul_acc;
    logic [31:0] mul_hi;
    logic [31:0] mul_lo;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] div_rem;
    logic        q_bit;
    logic [31:0] step_hi;
    logic [31:0] step_lo;
    logic [63:0] prod;
    logic [63:0] prod_fix;
    logic [31:0] final_hi;
    logic [31:0] final_lo;

    always_comb begin
        add_sum  = {1'b0, work_hi_q} + {1'b0, b_q};
        mul_acc  = work_lo_q[0] ? add_sum : {1'b0, work_hi_q};
        mul_hi   = mul_acc[32:1];
        mul_lo   = {mul_acc[0], work_lo_q[31:1]};

        shifted  = {work_hi_q, work_lo_q[31]};
        diff     = shifted - {1'b0, b_q};
        // Remainder stays below the divisor, so bit 32 of diff is a clean borrow flag.
        q_bit    = ~diff[32];
        div_rem  = q_bit ? diff[31:0] : shifted[31:0];

        step_hi  = is_div_q ? div_rem : mul_hi;
        step_lo  = is_div_q ? {work_lo_q[30:0], q_bit} : mul_lo;

        prod     = {step_hi, step_lo};
        prod_fix = neg_q ? (~prod + 64'd1) : prod;

        if (is_div_q) begin
            final_lo = neg_q ? (~step_lo + 32'd1) : step_lo;
            final_hi = neg_rem_q ? (~step_hi + 32'd1) : step_hi;
        end else begin
            final_hi = prod_fix[63:32];
            final_lo = prod_fix[31:0];
        end
    end

    // Control FSM with datapath and registered status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            count_q   <= 6'd0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            b_q       <= 32'd0;
            work_hi_q <= 32'd0;
            work_lo_q <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        is_div_q  <= op[1];
                        neg_q     <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        b_q       <= b_mag;
                        work_hi_q <= 32'd0;
                        work_lo_q <= a_mag;
                        if (div_by_zero) begin
                            // No iteration: results are defined directly from the operands.
                            hi_q    <= rsData;
                            lo_q    <= 32'hFFFF_FFFF;
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            count_q <= 6'd32;
                            state_q <= StRun;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        if (mthi) hi_q <= rsData;
                        if (mtlo) lo_q <= rsData;
                    end
                end
                StRun: begin
                    work_hi_q <= step_hi;
                    work_lo_q <= step_lo;
                    count_q   <= count_q - 6'd1;
                    if (count_q == 6'd1) begin
                        hi_q    <= final_hi;
                        lo_q    <= final_lo;
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases plus randomized operations checked
// against a 64-bit arithmetic reference model.
module tb_mult_div_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    mult_div_unit dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rsData (rsData),
        .rtData (rtData),
        .mthi   (mthi),
        .mtlo   (mtlo),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: signed/unsigned 64-bit arithmetic, truncating division.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = o[0] ? longint'({32'd0, a}) : longint'({{32{a[31]}}, a});
        sb = o[0] ? longint'({32'd0, b}) : longint'({{32{b[31]}}, b});
        if (!o[1]) begin
            p  = sa * sb;
            eh = p[63:32];
            el = p[31:0];
        end else if (b == 32'd0) begin
            eh = a;
            el = 32'hFFFF_FFFF;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            eh = r[31:0];
            el = q[31:0];
        end
    endfunction

    // Issue one operation and watch 40 edges. Optional disturbances: a second start with
    // moves and operand changes at edge disturb_at, reset at edge reset_at (-1 = none).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic mv, input int disturb_at, input int reset_at,
                          output int lat, output int dones, output bit busy_seen,
                          output bit hold_ok, output logic [31:0] rh, output logic [31:0] rl);
        logic [31:0] h0;
        logic [31:0] l0;
        h0 = hi;
        l0 = lo;
        op = o; rsData = a; rtData = b; start = 1'b1; mthi = mv; mtlo = mv;
        lat = -1; dones = 0; busy_seen = 1'b0; hold_ok = 1'b1;
        rh = 32'd0; rl = 32'd0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            start = 1'b0; mthi = 1'b0; mtlo = 1'b0; reset = 1'b0;
            if (busy === 1'b1) busy_seen = 1'b1;
            if (done === 1'b1) begin
                dones++;
                if (lat < 0) begin
                    lat = i; rh = hi; rl = lo;
                end
            end else if (lat < 0 && (hi !== h0 || lo !== l0)) begin
                hold_ok = 1'b0;
            end
            if (i + 1 == disturb_at) begin
                start = 1'b1; op = 2'b10; rsData = 32'd9; rtData = 32'd3; mthi = 1'b1; mtlo = 1'b1;
            end
            if (i + 1 == reset_at) reset = 1'b1;
        end
        if (lat < 0) begin
            rh = hi; rl = lo;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; op = 2'b00; rsData = 32'd0; rtData = 32'd0;
        mthi = 1'b0; mtlo = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
        n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
    endtask

    task automatic test_directed;
        logic [1:0]  ops [6];
        logic [31:0] as  [6];
        logic [31:0] bs  [6];
        logic [31:0] ehs [6];
        logic [31:0] els [6];
        int          lat, dones;
        bit          bs_seen, hold_ok;
        logic [31:0] rh, rl;
        ops = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11};
        as  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'h1234_5678};
        bs  = '{32'd2, 32'd2, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'd0};
        ehs = '{32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h1234_5678};
        els = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd3, 32'h8000_0000, 32'hFFFF_FFFF};
        for (int k = 0; k < 6; k++) begin
            run_op(ops[k], as[k], bs[k], 1'b0, -1, -1, lat, dones, bs_seen, hold_ok, rh, rl);
            n_checks++; if (rh !== ehs[k]) begin n_fail++; $display("FAIL dir%0d_hi got %h want %h", k, rh, ehs[k]); end
            n_checks++; if (rl !== els[k]) begin n_fail++; $display("FAIL dir%0d_lo got %h want %h", k, rl, els[k]); end
            n_checks++; if (lat !== (k == 5 ? 0 : 32)) begin n_fail++; $display("FAIL dir%0d_latency got %0d want %0d", k, lat, (k == 5 ? 0 : 32)); end
            n_checks++; if (bs_seen !== (k != 5)) begin n_fail++; $display("FAIL dir%0d_busy_seen got %b want %b", k, bs_seen, (k != 5)); end
            n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL dir%0d_done_count got %0d want 1", k, dones); end
        end
    endtask

    task automatic test_ignored_start;
        int          lat, dones;
        bit          bs_seen, hold_ok;
        logic [31:0] rh, rl;
        run_op(2'b01, 32'd3, 32'd5, 1'b0, 10, -1, lat, dones, bs_seen, hold_ok, rh, rl);
        n_checks++; if (rh !== 32'd0) begin n_fail++; $display("FAIL ign_hi got %h want 0", rh); end
        n_checks++; if (rl !== 32'hF) begin n_fail++; $display("FAIL ign_lo got %h want f", rl); end
        n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL ign_done_count got %0d want 1", dones); end
        n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL ign_latency got %0d want 32", lat); end
        n_checks++; if (hold_ok !== 1'b1) begin n_fail++; $display("FAIL ign_hold got %b want 1", hold_ok); end
    endtask

    task automatic test_start_wins;
        int          lat, dones;
        bit          bs_seen, hold_ok;
        logic [31:0] rh, rl;
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1, -1, -1, lat, dones, bs_seen, hold_ok, rh, rl);
        n_checks++; if (hold_ok !== 1'b1) begin n_fail++; $display("FAIL startwin_hold got %b want 1", hold_ok); end
        n_checks++; if (rh !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL startwin_hi got %h want ffffffff", rh); end
        n_checks++; if (rl !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL startwin_lo got %h want ffffffeb", rl); end
    endtask

    task automatic test_moves_and_abort;
        int          lat, dones;
        bit          bs_seen, hold_ok;
        logic [31:0] rh, rl;
        rsData = 32'hAAAA_0000; mthi = 1'b1;
        @(posedge clock); #1 mthi = 1'b0;
        n_checks++; if (hi !== 32'hAAAA_0000) begin n_fail++; $display("FAIL mthi_hi got %h want aaaa0000", hi); end
        rsData = 32'h0000_5555; mtlo = 1'b1;
        @(posedge clock); #1 mtlo = 1'b0;
        n_checks++; if (lo !== 32'h0000_5555) begin n_fail++; $display("FAIL mtlo_lo got %h want 00005555", lo); end
        n_checks++; if (hi !== 32'hAAAA_0000) begin n_fail++; $display("FAIL mtlo_hi_held got %h want aaaa0000", hi); end
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, 15, lat, dones, bs_seen, hold_ok, rh, rl);
        n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL abort_done_count got %0d want 0", dones); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL abort_hi got %h want 0", hi); end
        n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL abort_lo got %h want 0", lo); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
        rsData = 32'h1357_9BDF; mthi = 1'b1; mtlo = 1'b1;
        @(posedge clock); #1 mthi = 1'b0; mtlo = 1'b0;
        n_checks++; if (hi !== 32'h1357_9BDF) begin n_fail++; $display("FAIL both_hi got %h want 13579bdf", hi); end
        n_checks++; if (lo !== 32'h1357_9BDF) begin n_fail++; $display("FAIL both_lo got %h want 13579bdf", lo); end
    endtask

    task automatic test_reset_priority;
        rsData = 32'h0000_0001; rtData = 32'd1; op = 2'b01;
        reset = 1'b1; start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL rstprio_hi got %h want 0", hi); end
        n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL rstprio_lo got %h want 0", lo); end
        @(posedge clock); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstprio_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstprio_done got %b want 0", done); end
    endtask

    task automatic test_random;
        int          lat, dones;
        bit          bs_seen, hold_ok;
        logic [31:0] rh, rl, eh, el, a, b;
        logic [1:0]  o;
        bit          dz;
        for (int k = 0; k < 40; k++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: a = 32'h8000_0000;
                default: ;
            endcase
            model(o, a, b, eh, el);
            dz = o[1] && (b == 32'd0);
            run_op(o, a, b, 1'b0, -1, -1, lat, dones, bs_seen, hold_ok, rh, rl);
            n_checks++; if (rh !== eh) begin n_fail++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got %h want %h", k, o, a, b, rh, eh); end
            n_checks++; if (rl !== el) begin n_fail++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got %h want %h", k, o, a, b, rl, el); end
            n_checks++; if (lat !== (dz ? 0 : 32)) begin n_fail++; $display("FAIL rnd%0d_latency got %0d want %0d", k, lat, (dz ? 0 : 32)); end
            n_checks++; if (bs_seen !== !dz) begin n_fail++; $display("FAIL rnd%0d_busy_seen got %b want %b", k, bs_seen, !dz); end
            n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL rnd%0d_done_count got %0d want 1", k, dones); end
            n_checks++; if (hold_ok !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_hold got %b want 1", k, hold_ok); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignored_start();
        test_start_wins();
        test_moves_and_abort();
        test_reset_priority();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
